// File: rtl/fifo_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | fifo_ctrl_pkg - constants and state encoding for fifo_wr_arbiter   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fifo_ctrl_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 32;
  localparam int LEVEL_W    = 6;
  localparam int CLR_CYCLES = 2;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// +--------------------------------------------------------------------+
// | rr_arb2 - two-requester round-robin arbiter, registered last winner|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arb2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last_b_q;
  logic last_b_d;

  // On a tie, whoever did not win most recently goes first.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_b_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_b_d = last_b_q;
    if (gnt[1]) begin
      last_b_d = 1'b1;
    end else if (gnt[0]) begin
      last_b_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// +--------------------------------------------------------------------+
// | fifo_wr_arbiter - shares one FIFO write port between two producers,|
// | serves one reader, sequences clears and tracks occupancy. Rev 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int CLR_CYCLES = fifo_ctrl_pkg::CLR_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   REQ_A,
  input  logic [WIDTH-1:0]       DATA_A,
  output logic                   GNT_A,
  input  logic                   REQ_B,
  input  logic [WIDTH-1:0]       DATA_B,
  output logic                   GNT_B,
  input  logic                   RD_REQ,
  output logic                   RD_VALID,
  output logic [WIDTH-1:0]       RD_DATA,
  input  logic                   FLUSH,
  output logic [WIDTH-1:0]       FIFO_DATA_IN,
  output logic                   FIFO_WRITE,
  output logic                   FIFO_READ,
  output logic                   FIFO_CLEAR_N,
  input  logic [WIDTH-1:0]       FIFO_DATA_OUT,
  input  logic                   F_FULL_N,
  input  logic                   F_EMPTY_N,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   BUSY,
  output logic                   ERR
);

  localparam int                 LVL_W    = $clog2(DEPTH) + 1;
  localparam int                 CNT_W    = $clog2(CLR_CYCLES + 1);
  localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLR_CYCLES - 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;

  logic             gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic             fifo_write_q, fifo_write_d, fifo_read_q, fifo_read_d;
  logic [WIDTH-1:0] fifo_din_q, fifo_din_d, rd_data_q, rd_data_d;
  logic             rd_pend_q, rd_pend_d, rd_valid_q, rd_valid_d;
  logic             clear_n_q, clear_n_d, busy_q, busy_d, err_q, err_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic             run_now, run_next, room, wr, rd, chk, flag_bad;
  logic [1:0]       elig, gnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (FLUSH) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == CNT_LAST) begin
          state_d   = S_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (FLUSH) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // A producer granted last cycle sits out one cycle, which is what yields alternation.
  assign run_now  = (state_q == S_RUN) && !FLUSH;
  assign run_next = (state_d == S_RUN);
  assign room     = (level_q < LVL_FULL) && F_FULL_N;
  assign elig     = {REQ_B && !gnt_b_q && room, REQ_A && !gnt_a_q && room};

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RESET  (RESET),
    .req    (elig),
    .enable (run_now),
    .gnt    (gnt)
  );

  assign wr = |gnt;
  assign rd = run_now && RD_REQ && (level_q != '0);

  // Flags are only trusted once the FIFO has absorbed every issued command.
  assign chk      = (state_q == S_RUN) && !fifo_write_q && !fifo_read_q;
  assign flag_bad = ((level_q == LVL_FULL) != !F_FULL_N) ||
                    ((level_q == '0) != !F_EMPTY_N);

  always_comb begin
    gnt_a_d      = gnt[0];
    gnt_b_d      = gnt[1];
    fifo_write_d = wr;
    fifo_read_d  = rd;
    fifo_din_d   = gnt[1] ? DATA_B : (gnt[0] ? DATA_A : fifo_din_q);
    rd_pend_d    = run_next && fifo_read_q;
    rd_valid_d   = run_next && rd_pend_q;
    rd_data_d    = (run_next && rd_pend_q) ? FIFO_DATA_OUT : rd_data_q;
    clear_n_d    = run_next;
    busy_d       = !run_next;
    err_d        = run_next && (err_q || (chk && flag_bad));
    level_d      = level_q;
    if (!run_next) begin
      level_d = '0;
    end else if (wr && !rd) begin
      level_d = level_q + LVL_W'(1);
    end else if (rd && !wr) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      fifo_write_q <= 1'b0;
      fifo_read_q  <= 1'b0;
      fifo_din_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      clear_n_q    <= 1'b0;
      busy_q       <= 1'b1;
      err_q        <= 1'b0;
      level_q      <= '0;
    end else begin
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      fifo_write_q <= fifo_write_d;
      fifo_read_q  <= fifo_read_d;
      fifo_din_q   <= fifo_din_d;
      rd_pend_q    <= rd_pend_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      clear_n_q    <= clear_n_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      level_q      <= level_d;
    end
  end

  assign GNT_A        = gnt_a_q;
  assign GNT_B        = gnt_b_q;
  assign FIFO_WRITE   = fifo_write_q;
  assign FIFO_READ    = fifo_read_q;
  assign FIFO_DATA_IN = fifo_din_q;
  assign RD_VALID     = rd_valid_q;
  assign RD_DATA      = rd_data_q;
  assign FIFO_CLEAR_N = clear_n_q;
  assign BUSY         = busy_q;
  assign ERR          = err_q;
  assign LEVEL        = level_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_fifo_wr_arbiter - bench with a behavioural 32x8 registered FIFO |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fifo_wr_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_A = 1'b0, REQ_B = 1'b0, RD_REQ = 1'b0, FLUSH = 1'b0;
  logic [7:0] DATA_A = 8'h00, DATA_B = 8'h00;
  logic       GNT_A, GNT_B, RD_VALID, FIFO_WRITE, FIFO_READ, FIFO_CLEAR_N;
  logic [7:0] RD_DATA, FIFO_DATA_IN;
  logic [7:0] FIFO_DATA_OUT = 8'h00;
  logic       F_FULL_N, F_EMPTY_N;
  logic [5:0] LEVEL;
  logic       BUSY, ERR;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];

  logic [7:0] fmem [32];
  logic [4:0] wp = '0, rp = '0;
  int         fcnt = 0;
  logic       force_empty = 1'b0;

  always #5 CLK = ~CLK;

  fifo_wr_arbiter dut (
    .CLK (CLK), .RESET (RESET),
    .REQ_A (REQ_A), .DATA_A (DATA_A), .GNT_A (GNT_A),
    .REQ_B (REQ_B), .DATA_B (DATA_B), .GNT_B (GNT_B),
    .RD_REQ (RD_REQ), .RD_VALID (RD_VALID), .RD_DATA (RD_DATA),
    .FLUSH (FLUSH),
    .FIFO_DATA_IN (FIFO_DATA_IN), .FIFO_WRITE (FIFO_WRITE),
    .FIFO_READ (FIFO_READ), .FIFO_CLEAR_N (FIFO_CLEAR_N),
    .FIFO_DATA_OUT (FIFO_DATA_OUT),
    .F_FULL_N (F_FULL_N), .F_EMPTY_N (F_EMPTY_N),
    .LEVEL (LEVEL), .BUSY (BUSY), .ERR (ERR)
  );

  // Behavioural FIFO_32_8: clear dominates, registered read data.
  always @(posedge CLK) begin
    if (!FIFO_CLEAR_N) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= 0;
    end else begin
      if (FIFO_WRITE) begin
        fmem[wp] <= FIFO_DATA_IN;
        wp       <= 5'(wp + 5'd1);
      end
      if (FIFO_READ) begin
        FIFO_DATA_OUT <= fmem[rp];
        rp            <= 5'(rp + 5'd1);
      end
      fcnt <= fcnt + (FIFO_WRITE ? 1 : 0) - (FIFO_READ ? 1 : 0);
    end
  end

  assign F_FULL_N  = (fcnt != 32);
  assign F_EMPTY_N = force_empty | (fcnt != 0);

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One write through producer A (b=0) or B (b=1), followed by an idle cycle.
  task automatic write_word(input bit b, input logic [7:0] d);
    if (b) begin REQ_B = 1'b1; DATA_B = d; end
    else   begin REQ_A = 1'b1; DATA_A = d; end
    sb.push_back(d);
    tick();
    chk_eq("wr_gnt", 32'(b ? GNT_B : GNT_A), 1);
    chk_eq("wr_din", 32'(FIFO_DATA_IN), 32'(d));
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    tick();
  endtask

  always @(negedge CLK) begin
    if (!RESET && RD_VALID) begin
      chk_eq("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk_eq("rd_data", 32'(RD_DATA), 32'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and initial clear
    tick();
    chk_eq("rst_clear_n", 32'(FIFO_CLEAR_N), 0);
    chk_eq("rst_busy", 32'(BUSY), 1);
    chk_eq("rst_outs", 32'({GNT_A, GNT_B, RD_VALID, FIFO_WRITE, FIFO_READ, ERR}), 0);
    chk_eq("rst_level", 32'(LEVEL), 0);
    chk_eq("rst_data", 32'({RD_DATA, FIFO_DATA_IN}), 0);
    RESET = 1'b0;
    tick();
    chk_eq("clr2_clear_n", 32'(FIFO_CLEAR_N), 0);
    chk_eq("clr2_busy", 32'(BUSY), 1);
    tick();
    chk_eq("run_clear_n", 32'(FIFO_CLEAR_N), 1);
    chk_eq("run_busy", 32'(BUSY), 0);
    chk_eq("run_level", 32'(LEVEL), 0);
    chk_eq("run_err", 32'(ERR), 0);

    // Both producers contending: strict alternation, A first
    REQ_A = 1'b1; DATA_A = 8'h01;
    REQ_B = 1'b1; DATA_B = 8'h02;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_eq("rr_gnt_a", 32'(GNT_A), 32'(i % 2 == 0));
      chk_eq("rr_gnt_b", 32'(GNT_B), 32'(i % 2 == 1));
      chk_eq("rr_write", 32'(FIFO_WRITE), 1);
      chk_eq("rr_din", 32'(FIFO_DATA_IN), (i % 2 == 0) ? 32'h01 : 32'h02);
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    chk_eq("rr_level", 32'(LEVEL), 6);
    tick();
    chk_eq("idle_level", 32'(LEVEL), 6);

    // Single producer fills to DEPTH, every other cycle, then stalls
    REQ_A = 1'b1; DATA_A = 8'hA5;
    for (int k = 0; k < 56; k++) begin
      tick();
      chk_eq("fill_gnt_a", 32'(GNT_A), 32'(k < 52 && (k % 2 == 0)));
    end
    REQ_A = 1'b0;
    chk_eq("fill_level", 32'(LEVEL), 32);
    chk_eq("fill_err", 32'(ERR), 0);

    // Flush, then three writes and four reads
    FLUSH = 1'b1;
    sb.delete();
    tick();
    chk_eq("fl_clear_n", 32'(FIFO_CLEAR_N), 0);
    chk_eq("fl_level", 32'(LEVEL), 0);
    FLUSH = 1'b0;
    tick();
    chk_eq("fl2_clear_n", 32'(FIFO_CLEAR_N), 0);
    tick();
    chk_eq("fl_done", 32'({FIFO_CLEAR_N, BUSY}), 32'b10);
    write_word(1'b0, 8'h11);
    write_word(1'b1, 8'h22);
    write_word(1'b0, 8'h33);
    chk_eq("rd_level_pre", 32'(LEVEL), 3);
    RD_REQ = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_eq("rd_fifo_read", 32'(FIFO_READ), 32'(k <= 3));
      chk_eq("rd_valid", 32'(RD_VALID), 32'(k >= 3 && k <= 5));
      if (k == 4) RD_REQ = 1'b0;
    end
    chk_eq("rd_level_post", 32'(LEVEL), 0);
    chk_eq("rd_sb_empty", 32'(sb.size()), 0);

    // Same-cycle write and read at LEVEL=5
    for (int k = 0; k < 5; k++) write_word(k[0], 8'h40 + 8'(k));
    chk_eq("sc_level_pre", 32'(LEVEL), 5);
    REQ_A = 1'b1; DATA_A = 8'h55; sb.push_back(8'h55);
    RD_REQ = 1'b1;
    tick();
    REQ_A = 1'b0; RD_REQ = 1'b0;
    chk_eq("sc_both", 32'({GNT_A, FIFO_WRITE, FIFO_READ}), 32'b111);
    chk_eq("sc_level", 32'(LEVEL), 5);
    tick();
    chk_eq("sc_valid_early", 32'(RD_VALID), 0);
    tick();
    chk_eq("sc_valid", 32'(RD_VALID), 1);

    // Flush with a read in flight at LEVEL=10
    for (int k = 0; k < 5; k++) write_word(k[0], 8'h60 + 8'(k));
    chk_eq("ff_level_pre", 32'(LEVEL), 10);
    RD_REQ = 1'b1;
    tick();
    chk_eq("ff_read", 32'(FIFO_READ), 1);
    chk_eq("ff_level_rd", 32'(LEVEL), 9);
    RD_REQ = 1'b0; FLUSH = 1'b1;
    sb.delete();
    tick();
    FLUSH = 1'b0;
    chk_eq("ff_clear_n", 32'({FIFO_CLEAR_N, BUSY}), 32'b01);
    chk_eq("ff_level", 32'(LEVEL), 0);
    chk_eq("ff_valid1", 32'(RD_VALID), 0);
    tick();
    chk_eq("ff_valid2", 32'(RD_VALID), 0);
    chk_eq("ff_clear_n2", 32'(FIFO_CLEAR_N), 0);
    tick();
    chk_eq("ff_done", 32'({FIFO_CLEAR_N, BUSY}), 32'b10);
    chk_eq("ff_level_done", 32'(LEVEL), 0);

    // Flag disagreement sets sticky ERR, cleared only by a flush
    force_empty = 1'b1;
    tick();
    tick();
    chk_eq("err_set", 32'(ERR), 1);
    force_empty = 1'b0;
    tick();
    tick();
    chk_eq("err_sticky", 32'(ERR), 1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk_eq("err_cleared", 32'(ERR), 0);
    tick();
    tick();
    tick();
    chk_eq("err_after_clear", 32'({ERR, BUSY}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Sequences one FIFO_32_8 instance (32 x 8, registered read) and shares its write port between two producers, A and B, using round-robin arbitration.
- Serves one consumer through a read-request/valid interface.
- Owns FIFO clear sequencing at reset and on flush, and keeps an exact occupancy count.
- Sits directly between the producers/consumer and the FIFO. It is the only driver of the FIFO control pins.

Parameters:
WIDTH, 8, data width; must match the FIFO.
DEPTH, 32, FIFO depth; the count is $clog2(DEPTH)+1 bits wide.
CLR_CYCLES, 2, number of cycles FIFO_CLEAR_N is held low per clear.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
RESET  in  1  synchronous reset, active-high.
REQ_A  in  1  producer A has a word.
DATA_A  in  WIDTH  producer A word; stable while REQ_A=1.
GNT_A  out  1  one-cycle pulse: A's word is being written this cycle.
REQ_B  in  1  producer B has a word.
DATA_B  in  WIDTH  producer B word.
GNT_B  out  1  one-cycle pulse for B.
RD_REQ  in  1  consumer wants one word.
RD_VALID  out  1  one-cycle pulse: RD_DATA is valid.
RD_DATA  out  WIDTH  word returned to the consumer.
FLUSH  in  1  one-cycle pulse: discard all FIFO contents.
FIFO_DATA_IN  out  WIDTH  to FIFO DATA_IN.
FIFO_WRITE  out  1  to FIFO WRITE.
FIFO_READ  out  1  to FIFO READ.
FIFO_CLEAR_N  out  1  to FIFO CLEAR_N, active-low.
FIFO_DATA_OUT  in  WIDTH  from FIFO DATA_OUT.
F_FULL_N  in  1  FIFO full flag, active-low.
F_EMPTY_N  in  1  FIFO empty flag, active-low.
LEVEL  out  6  occupancy count, 0..32.
BUSY  out  1  high while a clear is in progress.
ERR  out  1  sticky flag: FIFO flags disagree with LEVEL.

Behaviour:
- Clock and reset: one clock, CLK; reset is RESET, synchronous and active-high.
- Registered outputs: all outputs are registered. Decisions are made at rising edge N from inputs sampled at N, and take effect in cycle N (the cycle following edge N).
- Reset values: GNT_A=0, GNT_B=0, RD_VALID=0, RD_DATA=0, FIFO_WRITE=0, FIFO_READ=0, FIFO_DATA_IN=0, FIFO_CLEAR_N=0, LEVEL=0, BUSY=1, ERR=0.
- After reset, the FSM state is CLEAR and the clear counter is 0.
- FSM, CLEAR state: FIFO_CLEAR_N=0 and BUSY=1 for CLR_CYCLES cycles. No grants and no reads. LEVEL forced to 0, any pending RD_VALID is cancelled, ERR cleared. Then go to RUN.
- FSM, RUN state: normal operation. FLUSH sampled high goes to CLEAR. A FLUSH arriving while already in CLEAR restarts the clear counter.
- RESET has priority over everything at any time, including mid-clear or mid-read; the FSM returns to CLEAR.
- Write eligibility: producer X is eligible at edge N if REQ_X=1, X was not granted in cycle N-1, LEVEL < DEPTH, and F_FULL_N=1.
- Write arbitration (rr_arb2):
  - If one producer is eligible, it wins.
  - If both are eligible, the producer not granted most recently wins.
  - The last-winner pointer resets to B, so A wins the first tie.
- Write issue: the winner's GNT_X=1, FIFO_WRITE=1 and FIFO_DATA_IN=DATA_X, all in the same cycle. Each producer gets at most one word every 2 cycles; the FIFO accepts at most one write per cycle.
- Read issue: if RD_REQ=1 and LEVEL > 0 (counting any write granted in that same cycle as not yet present), FIFO_READ=1 for one cycle.
- Read return: in the following cycle, RD_DATA is loaded from FIFO_DATA_OUT and RD_VALID=1. Total latency is 2 cycles from the RD_REQ sampling edge to RD_VALID.
- Empty read: RD_REQ while LEVEL=0 is dropped silently. There is no queuing; the consumer must re-request.
- LEVEL update: +1 on a write cycle, -1 on a read cycle, unchanged when both happen in the same cycle. LEVEL saturates only by the eligibility rules and never exceeds DEPTH or goes below 0.
- Wrap-around: LEVEL is 6 bits, so 32 is representable; FIFO USE_DW is not used because it wraps to 0 at 32.
- ERR check: in RUN, when no write or read was issued in the previous cycle:
  - ERR is set if (LEVEL==DEPTH) != (F_FULL_N==0).
  - ERR is set if (LEVEL==0) != (F_EMPTY_N==0).
  - ERR is cleared only by reset or a clear.

Decomposition:
- Package fifo_ctrl_pkg:
  - localparams FIFO_WIDTH=8, FIFO_DEPTH=32, LEVEL_W=6, CLR_CYCLES=2.
  - typedef enum logic [0:0] {S_CLEAR, S_RUN} ctrl_state_t.
- Sub-module rr_arb2: a 2-requester round-robin arbiter with a registered last-winner pointer.
  - Inputs: CLK, RESET, req[1:0], enable.
  - Output: one-hot gnt[1:0].
  - The top level owns the FSM, LEVEL, the read pipeline and ERR.

Test Plan:
- RESET high for 1 cycle, then low: FIFO_CLEAR_N=0 for exactly 2 cycles with BUSY=1, then BUSY=0, LEVEL=0, ERR=0, and all other outputs at reset values.
- REQ_A and REQ_B held high with DATA_A=0x01 and DATA_B=0x02, for 6 cycles: grants go A,B,A,B,A,B on consecutive cycles; FIFO_DATA_IN follows 01,02,01,02,01,02; LEVEL=6.
- REQ_A only, held high: GNT_A pulses every other cycle; fill to LEVEL=32, then no more grants while F_FULL_N=0.
- Write 0x11, 0x22, 0x33, then RD_REQ for 4 cycles: RD_VALID with 0x11, 0x22, 0x33 at 2-cycle latency; the 4th request is dropped; LEVEL=0.
- With LEVEL=5, a same-cycle grant and read: LEVEL stays 5.
- With LEVEL=10, FLUSH pulse during an outstanding read: RD_VALID is suppressed, FIFO_CLEAR_N is low for 2 cycles, LEVEL=0.
- Force F_EMPTY_N=1 while LEVEL=0 and idle: ERR goes to 1 and stays set until the next FLUSH.
